// File: rtl/game_pkg.sv
// Types and sizing shared by the whack-a-mole game blocks and the LFSR random source.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPTURE,
        SHOW,
        GAP
    } state_e;

    localparam int NUM_LEDS_DEFAULT = 18;
    localparam int IDX_W            = 5;
    localparam int RAND_W           = 18;

endpackage

// File: rtl/mole_index_map.sv
// Folds a random value down to a mole index and never picks the same mole twice in a row.
module mole_index_map
    import game_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEFAULT
)(
    input  logic [RAND_W-1:0] rand_value,
    input  logic [IDX_W-1:0]  prev_idx,
    output logic [IDX_W-1:0]  idx
);

    localparam int EXT_W = IDX_W + 1;

    logic [EXT_W-1:0] raw;
    logic [IDX_W-1:0] f;
    logic             unused_rand_hi;

    // Only the low five bits are random enough to need; one subtraction suffices for 17..32 LEDs.
    assign unused_rand_hi = ^rand_value[RAND_W-1:IDX_W];
    assign raw = {1'b0, rand_value[IDX_W-1:0]};
    assign f   = (raw >= EXT_W'(NUM_LEDS)) ? IDX_W'(raw - EXT_W'(NUM_LEDS)) : raw[IDX_W-1:0];

    assign idx = (f != prev_idx)                ? f
               : (f == IDX_W'(NUM_LEDS - 1))    ? '0
               :                                  f + IDX_W'(1);

endmodule

// File: rtl/mole_spawner.sv
// Requests a random mole, lights it for a bounded time and judges switch hits against it.
module mole_spawner
    import game_pkg::*;
#(
    parameter int NUM_LEDS   = NUM_LEDS_DEFAULT,
    parameter int ON_CYCLES  = 50000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int SCORE_W    = 8
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                score_clr,
    input  logic [RAND_W-1:0]   rand_value,
    output logic                rand_req,
    input  logic [NUM_LEDS-1:0] hit_sw,
    output logic [NUM_LEDS-1:0] led_mole,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic                wrong_pulse,
    output logic [SCORE_W-1:0]  score
);

    localparam int TMR_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]    ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]    GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

    state_e              state_q;
    logic [TMR_W-1:0]    timer_q;
    logic [IDX_W-1:0]    prev_idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [NUM_LEDS-1:0] hit_sw_d_q;
    logic [NUM_LEDS-1:0] led_q;
    logic [NUM_LEDS-1:0] rise_d;
    logic                req_q;
    logic                hit_q;
    logic                miss_q;
    logic                wrong_q;
    logic [SCORE_W-1:0]  score_q;
    logic                hit_now;
    logic                wrong_now;

    mole_index_map #(.NUM_LEDS(NUM_LEDS)) u_index_map (
        .rand_value (rand_value),
        .prev_idx   (prev_idx_q),
        .idx        (idx_d)
    );

    // led_q is one-hot while a mole is lit, so it doubles as the hit mask.
    assign rise_d    = hit_sw & ~hit_sw_d_q;
    assign hit_now   = |(rise_d & led_q);
    assign wrong_now = |(rise_d & ~led_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            prev_idx_q  <= '0;
            hit_sw_d_q  <= '0;
            led_q       <= '0;
            req_q       <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            wrong_q     <= 1'b0;
            score_q     <= '0;
        end else begin
            hit_sw_d_q <= hit_sw;
            req_q      <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            wrong_q    <= 1'b0;

            if (!enable) begin
                state_q <= IDLE;
                led_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                    REQ: begin
                        state_q <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (rand_value == '0) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            prev_idx_q <= idx_d;
                            led_q      <= LED_ONE << idx_d;
                            timer_q    <= ON_LOAD;
                            state_q    <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (hit_now) begin
                            hit_q   <= 1'b1;
                            led_q   <= '0;
                            timer_q <= GAP_LOAD;
                            state_q <= GAP;
                            if (score_q != '1) begin
                                score_q <= score_q + SCORE_W'(1);
                            end
                        end else if (timer_q == '0) begin
                            miss_q  <= 1'b1;
                            led_q   <= '0;
                            timer_q <= GAP_LOAD;
                            state_q <= GAP;
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                            wrong_q <= wrong_now;
                        end
                    end
                    GAP: begin
                        if (timer_q == '0) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        led_q   <= '0;
                    end
                endcase
            end

            // Placed last so a clear overrides a same-cycle hit increment.
            if (score_clr) begin
                score_q <= '0;
            end
        end
    end

    assign rand_req    = req_q;
    assign led_mole    = led_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign wrong_pulse = wrong_q;
    assign score       = score_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: directed game scenarios plus randomized play against a behavioural model.
module tb_mole_spawner;

    localparam int NL = 18;
    localparam int ON = 8;
    localparam int GP = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          score_clr = 1'b0;
    logic [17:0]   rand_value = '0;
    logic          rand_req;
    logic [NL-1:0] hit_sw = '0;
    logic [NL-1:0] led_mole;
    logic          hit_pulse;
    logic          miss_pulse;
    logic          wrong_pulse;
    logic [SW-1:0] score;

    logic [17:0]   um_rand = '0;
    logic [4:0]    um_prev = '0;
    logic [4:0]    um_idx;

    always #5 clk = ~clk;

    mole_spawner #(.NUM_LEDS(NL), .ON_CYCLES(ON), .GAP_CYCLES(GP), .SCORE_W(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .score_clr   (score_clr),
        .rand_value  (rand_value),
        .rand_req    (rand_req),
        .hit_sw      (hit_sw),
        .led_mole    (led_mole),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .wrong_pulse (wrong_pulse),
        .score       (score)
    );

    mole_index_map #(.NUM_LEDS(NL)) u_map_ut (
        .rand_value (um_rand),
        .prev_idx   (um_prev),
        .idx        (um_idx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: what the player should see, tracked as countdowns of lit and dark cycles.
    bit            m_idle = 1'b1;
    bit            m_req  = 1'b0;
    bit            m_cap  = 1'b0;
    int            m_lit  = -1;
    int            m_left = 0;
    int            m_gap  = 0;
    int            m_prev = 0;
    int            m_score = 0;
    logic [NL-1:0] m_hsd = '0;
    logic [NL-1:0] e_led = '0;
    bit            e_req = 1'b0;
    bit            e_hit = 1'b0;
    bit            e_miss = 1'b0;
    bit            e_wrong = 1'b0;
    int            rq[$];

    function automatic int model_idx(int v, int prev);
        int f;
        f = (v % 32) % NL;
        if (f == prev) f = (f + 1) % NL;
        return f;
    endfunction

    task automatic model_step();
        logic [NL-1:0] rise;
        int            idx;
        rise  = hit_sw & ~m_hsd;
        m_hsd = hit_sw;
        e_req = 0; e_hit = 0; e_miss = 0; e_wrong = 0;
        if (reset) begin
            m_idle = 1; m_req = 0; m_cap = 0; m_lit = -1; m_gap = 0;
            m_prev = 0; m_score = 0; e_led = '0; m_hsd = '0;
            return;
        end
        if (!enable) begin
            m_idle = 1; m_req = 0; m_cap = 0; m_lit = -1; m_gap = 0; e_led = '0;
        end else if (m_idle) begin
            m_idle = 0; m_req = 1; e_req = 1;
        end else if (m_req) begin
            m_req = 0; m_cap = 1;
        end else if (m_cap) begin
            m_cap = 0;
            if (rand_value == 0) begin
                m_req = 1; e_req = 1;
            end else begin
                idx = model_idx(int'(rand_value), m_prev);
                m_prev = idx; m_lit = idx; m_left = ON;
                e_led = '0; e_led[idx] = 1'b1;
            end
        end else if (m_lit >= 0) begin
            if (rise[m_lit]) begin
                e_hit = 1; m_score = (m_score < 255) ? m_score + 1 : 255;
                m_lit = -1; e_led = '0; m_gap = GP;
            end else if (m_left == 1) begin
                e_miss = 1; m_lit = -1; e_led = '0; m_gap = GP;
            end else begin
                m_left--;
                if (rise != '0) e_wrong = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                m_req = 1; e_req = 1;
            end
        end
        if (score_clr) m_score = 0;
    endtask

    function automatic logic [17:0] next_rand();
        if (rq.size() > 0) return 18'(rq.pop_front());
        if ($urandom_range(7) == 0) return '0;
        return 18'($urandom_range(262143, 1));
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rand_req", rand_req, e_req);
        chk("led_mole", led_mole, e_led);
        chk("hit_pulse", hit_pulse, e_hit);
        chk("miss_pulse", miss_pulse, e_miss);
        chk("wrong_pulse", wrong_pulse, e_wrong);
        chk("score", score, m_score);
        if (e_req) rand_value = next_rand();
    endtask

    task automatic wait_lit(input string nm);
        int n;
        n = 0;
        while (led_mole == '0 && n < 64) begin
            tick();
            n++;
        end
        chk(nm, (led_mole != '0), 1);
    endtask

    task automatic map_case(input string nm, input int v, input int p, input int exp);
        um_rand = 18'(v);
        um_prev = 5'(p);
        #1;
        chk(nm, um_idx, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;

        map_case("map_23_p0", 23, 0, 5);
        map_case("map_5_p5", 5, 5, 6);
        map_case("map_49_p17", 49, 17, 0);
        map_case("map_65_p0", 65, 0, 1);
        map_case("map_31_p0", 31, 0, 13);
        map_case("map_36_p4", 36, 4, 5);
        chk("model_23", model_idx(23, 0), 5);
        chk("model_49_p17", model_idx(49, 17), 0);
        chk("model_65", model_idx(65, 0), 1);

        rq = '{23, 5, 0, 49, 49, 65};

        // Reset and the first mole.
        repeat (3) tick();
        chk("rst_req", rand_req, 0);
        chk("rst_led", led_mole, 0);
        chk("rst_pulses", {hit_pulse, miss_pulse, wrong_pulse}, 0);
        chk("rst_score", score, 0);
        reset = 1'b0;
        enable = 1'b1;
        tick();
        chk("req_first", rand_req, 1);
        tick();
        chk("req_one_cycle", rand_req, 0);
        tick();
        chk("first_led", led_mole, 32);

        // Hit on the third lit cycle, then a four-cycle gap.
        tick();
        tick();
        hit_sw[5] = 1'b1;
        tick();
        chk("hit_pulse_lit3", hit_pulse, 1);
        chk("hit_score", score, 1);
        chk("hit_led_off", led_mole, 0);
        hit_sw = '0;
        repeat (3) tick();
        chk("gap_no_req", rand_req, 0);
        tick();
        chk("gap_len", rand_req, 1);
        tick();
        tick();
        chk("repeat_avoid", led_mole, 64);

        // Wrong switch, then timeout.
        hit_sw[2] = 1'b1;
        tick();
        chk("wrong_pulse_sw2", wrong_pulse, 1);
        chk("wrong_no_hit", hit_pulse, 0);
        repeat (6) tick();
        chk("lit_8th", led_mole, 64);
        chk("no_early_miss", miss_pulse, 0);
        tick();
        chk("miss_after_8", miss_pulse, 1);
        chk("miss_led_off", led_mole, 0);
        repeat (4) tick();
        chk("req_after_miss", rand_req, 1);
        tick();
        tick();
        chk("zero_retry", rand_req, 1);
        chk("zero_led_dark", led_mole, 0);
        tick();
        tick();
        chk("fold_17", led_mole, 131072);

        // Hit on the expiry cycle beats the miss.
        repeat (7) tick();
        hit_sw[17] = 1'b1;
        tick();
        chk("expiry_hit", hit_pulse, 1);
        chk("expiry_no_miss", miss_pulse, 0);
        chk("expiry_score", score, 2);
        hit_sw = '0;
        wait_lit("wait_wrap");
        chk("fold_wrap", led_mole, 1);

        // Abort by enable, then resume.
        enable = 1'b0;
        tick();
        chk("abort_led", led_mole, 0);
        chk("abort_score", score, 2);
        enable = 1'b1;
        wait_lit("wait_65");
        chk("fold_65", led_mole, 2);

        // Drive the score to saturation.
        for (int k = 0; k < 300 && m_score < 255; k++) begin
            hit_sw = '0;
            wait_lit("sat_wait");
            hit_sw = e_led;
            tick();
        end
        chk("score_at_max", score, 255);
        hit_sw = '0;
        wait_lit("sat_wait2");
        hit_sw = e_led;
        tick();
        chk("sat_hit_pulse", hit_pulse, 1);
        chk("score_sat", score, 255);

        // Clear coinciding with a hit.
        hit_sw = '0;
        wait_lit("clr_wait");
        hit_sw = e_led;
        score_clr = 1'b1;
        tick();
        score_clr = 1'b0;
        chk("clr_hit_pulse", hit_pulse, 1);
        chk("clr_wins", score, 0);

        // Reset in the middle of a gap.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_gap_led", led_mole, 0);
        chk("rst_gap_req", rand_req, 0);
        chk("rst_gap_score", score, 0);
        chk("rst_gap_pulses", {hit_pulse, miss_pulse, wrong_pulse}, 0);

        // Randomized play.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(499) == 0);
            enable    = ($urandom_range(49) != 0);
            score_clr = ($urandom_range(99) == 0);
            r = int'($urandom_range(9));
            if (r < 3) begin
                int b;
                b = int'($urandom_range(NL - 1));
                hit_sw[b] = ~hit_sw[b];
            end else if (r == 3) begin
                hit_sw = hit_sw | e_led;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
